// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID / build-timestamp checker:
// FSM state encoding and the default reference constants.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_e;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1498439491;

  localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-request watchdog: counts cycles since the last clear and flags the
// cycle on which LIMIT cycles have been spent waiting.
module sysid_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count_q, count_d;

  // Saturate so a long stall after expiry cannot wrap back below LAST.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q >= LAST);

endmodule

// File: rtl/sysid_checker.sv
// Reads the ID and timestamp words over Avalon-MM, compares them against the
// expected constants, and retries each word on timeout.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_e              state_q, state_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic                timeout_err_q, timeout_err_d;
  logic [31:0]         captured_id_q, captured_id_d, captured_ts_q, captured_ts_d;
  logic                ctr_clear, ctr_enable, ctr_expired;
  logic                in_req, in_wait, is_ts, accepted, got_data;

  assign in_req   = (state_q == REQ_ID) || (state_q == REQ_TS);
  assign in_wait  = (state_q == WAIT_ID) || (state_q == WAIT_TS);
  assign is_ts    = (state_q == REQ_TS) || (state_q == WAIT_TS);
  assign accepted = in_req && !avm_waitrequest;
  // Data is only legal in WAIT_x or on the accept cycle of a zero-latency slave.
  assign got_data = avm_readdatavalid && (accepted || in_wait);
  assign ctr_enable = in_req || in_wait;

  sysid_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(ctr_expired)
  );

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_err_d = timeout_err_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;
    ctr_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = REQ_ID;
          retry_d       = '0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
          ctr_clear     = 1'b1;
        end
      end
      REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
        if (got_data) begin
          if (is_ts) begin
            captured_ts_d = avm_readdata;
            ts_ok_d       = (avm_readdata == EXPECTED_TS);
            state_d       = FINISH;
          end else begin
            captured_id_d = avm_readdata;
            id_ok_d       = (avm_readdata == EXPECTED_ID);
            state_d       = REQ_TS;
            retry_d       = '0;
            ctr_clear     = 1'b1;
          end
        end else if (accepted) begin
          // An accepted read is outstanding; a timeout is only acted on from WAIT_x.
          state_d = is_ts ? WAIT_TS : WAIT_ID;
        end else if (ctr_expired) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d   = retry_q + 1'b1;
            state_d   = is_ts ? REQ_TS : REQ_ID;
            ctr_clear = 1'b1;
          end else begin
            timeout_err_d = 1'b1;
            state_d       = FINISH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      retry_q       <= '0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      captured_id_q <= '0;
      captured_ts_q <= '0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_err_q <= timeout_err_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  assign avm_read    = in_req;
  assign avm_address = (state_q == REQ_TS);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_err_q;
  assign captured_id = captured_id_q;
  assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: scripted Avalon slave driven by a
// per-request plan queue, plus a word-level model of the check sequence.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1498439491;
  localparam int unsigned T_CYC  = 8;
  localparam int unsigned N_RETRY = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] captured_id, captured_ts;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          w;
    int          l;
    bit          respond;
    logic [31:0] data;
  } plan_t;

  plan_t       plan_q[$];
  plan_t       cur;
  bit          loaded = 0, pend = 0, held = 0, held_addr = 0;
  int          wait_cnt = 0, pend_cnt = 0;
  logic [31:0] pend_data = '0;
  int          id_reqs = 0, ts_reqs = 0, done_cnt = 0;
  bit          stray = 0;
  logic [31:0] stray_data = '0;
  logic [31:0] model_cid = '0, model_cts = '0;

  sysid_checker #(
    .TIMEOUT_CYCLES(T_CYC),
    .MAX_RETRIES   (N_RETRY)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout_err      (timeout_err),
    .captured_id      (captured_id),
    .captured_ts      (captured_ts)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) if (reset_n && done) done_cnt++;

  // Slave: drives waitrequest/readdatavalid for the current cycle from the plan.
  always @(negedge clock) begin
    if (!reset_n) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      loaded = 0; pend = 0; held = 0;
      plan_q.delete();
    end else begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (held) begin
        check("hold_read", avm_read, 1);
        check("hold_addr", avm_address, held_addr);
      end
      held = 0;
      if (pend) begin
        if (pend_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
          pend = 0;
        end else pend_cnt--;
      end
      if (avm_read) begin
        if (!loaded) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else cur = '{w: 0, l: 0, respond: 1'b1, data: 32'hDEADBEEF};
          loaded = 1; wait_cnt = 0;
        end
        if (wait_cnt < cur.w) begin
          avm_waitrequest = 1'b1;
          wait_cnt++;
          held = 1; held_addr = avm_address;
        end else begin
          loaded = 0;
          if (avm_address) ts_reqs++; else id_reqs++;
          if (cur.respond) begin
            if (cur.l == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = cur.data;
            end else begin
              pend = 1; pend_cnt = cur.l - 1; pend_data = cur.data;
            end
          end
        end
      end
      if (stray) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = stray_data;
      end
    end
  end

  task automatic push(input int w, input int l, input bit resp, input logic [31:0] d);
    plan_t p;
    p = '{w: w, l: l, respond: resp, data: d};
    plan_q.push_back(p);
  endtask

  task automatic run_case(input string tag, input bit e_id, input bit e_ts, input bit e_terr,
                          input logic [31:0] e_cid, input logic [31:0] e_cts,
                          input int e_idr, input int e_tsr, input int max_lat, input int restart_at);
    int base, lat;
    base = done_cnt; id_reqs = 0; ts_reqs = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; lat = 1;
    while (!done && lat < 400) begin
      @(negedge clock);
      lat++;
      start = (lat == restart_at);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency_ok"}, (lat <= max_lat), 1);
    repeat (3) @(negedge clock);
    check({tag, "_done_pulses"}, done_cnt - base, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_id_ok"}, id_ok, e_id);
    check({tag, "_ts_ok"}, ts_ok, e_ts);
    check({tag, "_timeout_err"}, timeout_err, e_terr);
    check({tag, "_captured_id"}, captured_id, e_cid);
    check({tag, "_captured_ts"}, captured_ts, e_cts);
    check({tag, "_id_reqs"}, id_reqs, e_idr);
    check({tag, "_ts_reqs"}, ts_reqs, e_tsr);
    $display("case %s lat=%0d id_ok=%0b ts_ok=%0b terr=%0b id=%h ts=%h reqs=%0d/%0d",
             tag, lat, id_ok, ts_ok, timeout_err, captured_id, captured_ts, id_reqs, ts_reqs);
    model_cid = e_cid; model_cts = e_cts;
  endtask

  // Word-level model: each attempt either returns data or times out; a word
  // gets 1+N_RETRY attempts before the whole sequence is abandoned.
  task automatic random_case(input int n);
    bit e_ok[2];
    bit e_terr;
    int reqs[2];
    logic [31:0] cap[2];
    logic [31:0] expv[2];
    expv[0] = EXP_ID; expv[1] = EXP_TS;
    cap[0] = model_cid; cap[1] = model_cts;
    e_ok[0] = 0; e_ok[1] = 0; e_terr = 0; reqs[0] = 0; reqs[1] = 0;
    for (int word = 0; word < 2 && !e_terr; word++) begin
      int tries = 0;
      bit got = 0;
      while (!got && !e_terr) begin
        bit resp;
        logic [31:0] d;
        resp = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 1) == 1) ? expv[word] : $urandom;
        push($urandom_range(0, 3), $urandom_range(0, 3), resp, d);
        reqs[word]++;
        if (resp) begin
          got = 1; cap[word] = d; e_ok[word] = (d == expv[word]);
        end else if (tries == int'(N_RETRY)) e_terr = 1;
        else tries++;
      end
    end
    run_case($sformatf("rand%0d", n), e_ok[0], e_ok[1], e_terr, cap[0], cap[1],
             reqs[0], reqs[1], 400, 0);
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_flags", {id_ok, ts_ok, timeout_err}, 0);
    check("rst_cid", captured_id, 0);
    check("rst_cts", captured_ts, 0);
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);

    push(0, 0, 1, EXP_ID); push(0, 0, 1, EXP_TS);
    run_case("zero_lat", 1, 1, 0, EXP_ID, EXP_TS, 1, 1, 4, 0);

    push(5, 1, 1, EXP_ID); push(0, 2, 1, EXP_TS);
    run_case("waitreq5", 1, 1, 0, EXP_ID, EXP_TS, 1, 1, 400, 0);

    push(0, 0, 1, EXP_ID); push(1, 1, 1, 32'h12345678);
    run_case("ts_bad", 1, 0, 0, EXP_ID, 32'h12345678, 1, 1, 400, 0);

    push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
    run_case("id_timeout", 0, 0, 1, EXP_ID, 32'h12345678, 3, 0, 400, 0);

    push(0, 0, 1, EXP_ID); push(0, 3, 1, EXP_TS);
    run_case("restart_busy", 1, 1, 0, EXP_ID, EXP_TS, 1, 1, 400, 2);

    // Reset while the TS read is outstanding, then a late response.
    push(0, 0, 1, 32'h0BAD_0001); push(0, 4, 1, EXP_TS);
    id_reqs = 0; ts_reqs = 0; guard = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (ts_reqs == 0 && guard < 50) begin
      @(negedge clock); guard++;
    end
    check("mid_ts_accepted", ts_reqs, 1);
    @(negedge clock); reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_read", {avm_read, avm_address}, 0);
    check("mid_rst_cid", captured_id, 0);
    check("mid_rst_cts", captured_ts, 0);
    check("mid_rst_flags", {id_ok, ts_ok, timeout_err, done}, 0);
    repeat (2) @(negedge clock); reset_n = 1'b1;
    guard = done_cnt;
    @(negedge clock); stray = 1; stray_data = EXP_TS;
    @(negedge clock); stray = 0;
    repeat (4) @(negedge clock);
    check("stray_busy", busy, 0);
    check("stray_read", avm_read, 0);
    check("stray_cts", captured_ts, 0);
    check("stray_ts_ok", ts_ok, 0);
    check("stray_no_done", done_cnt - guard, 0);
    $display("case reset_mid_ts busy=%0b cts=%h", busy, captured_ts);
    model_cid = '0; model_cts = '0;

    for (int n = 0; n < 20; n++) random_case(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
